// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the memory port arbiter.
//   - arb_state_t : grant FSM states
//   - side_t      : requester side (I-cache / D-cache), also the round-robin pointer
//   - DATA_PART_OFFSET : default base of the data region, added to D-side addresses
package mem_arb_pkg;

    localparam logic [31:0] DATA_PART_OFFSET = 32'h0000_D000;

    typedef enum logic [2:0] {
        IDLE,
        IRD,
        DRD,
        DWR,
        RESP
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// mem_arb_rr_pick
//   Combinational two-way round-robin picker.
//   Ports:
//     i_req_i    - I-side request pending
//     i_req_d    - D-side request pending (read or write)
//     i_ptr      - side granted last (SIDE_I / SIDE_D encoding)
//     o_gnt_side - side to grant (SIDE_I / SIDE_D encoding)
//     o_gnt_vld  - at least one side is pending
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_ptr,
    output logic o_gnt_side,
    output logic o_gnt_vld
);

    // The side that did not win last time has priority; if it is idle the
    // other side takes the grant.
    always_comb begin
        o_gnt_vld = i_req_i | i_req_d;
        if (i_ptr == SIDE_D) begin
            o_gnt_side = i_req_i ? SIDE_I : SIDE_D;
        end else begin
            o_gnt_side = i_req_d ? SIDE_D : SIDE_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory read channel and one write channel between the
//   I-cache read port and the D-cache read/write ports. One transaction is in
//   flight at a time; I-side and D-side alternate round-robin, and inside the
//   D-side a pending write beats a pending read. D-side addresses get the data
//   region offset added (wrapping). All memory-side outputs are registered.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     Enables a 16-bit watchdog; after TIMEOUT_CYCLES busy cycles without a
//     memory done, the request is aborted, the owner gets its done pulse (with
//     an all-zero line for reads) and o_timeout_err is set until reset.
//     Without the macro the FSM waits indefinitely and o_timeout_err is 0.
//
//   Ports:
//     i_clk, i_rst                 - clock, synchronous active-high reset
//     i_icache_read_*              - I-side level read request / address
//     o_icache_cache_line/_done    - I-side returned line and done pulse
//     i_dcache_read_*              - D-side level read request / address
//     o_dcache_cache_line/_done    - D-side returned line and done pulse
//     i_dcache_write_*             - D-side level write request, addr/data/strobe
//     o_dcache_write_done          - D-side write done pulse
//     o_mem_read_req/_address      - memory read request (held until done)
//     i_mem_read_done, i_cache_line- memory read completion and data
//     o_mem_write_*, o_write_strobe- memory write request (held until done)
//     i_mem_write_done             - memory write completion
//     o_timeout_err                - sticky watchdog error
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    CACHE_LINE_WIDTH = 256,
    parameter logic [ADDR_WIDTH-1:0] DATA_OFFSET      = ADDR_WIDTH'(DATA_PART_OFFSET),
    parameter int                    TIMEOUT_CYCLES   = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst,

    input  logic                        i_icache_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_icache_read_address,
    output logic [CACHE_LINE_WIDTH-1:0] o_icache_cache_line,
    output logic                        o_icache_read_done,

    input  logic                        i_dcache_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_dcache_read_address,
    output logic [CACHE_LINE_WIDTH-1:0] o_dcache_cache_line,
    output logic                        o_dcache_read_done,

    input  logic                        i_dcache_write_valid,
    input  logic [ADDR_WIDTH-1:0]       i_dcache_write_address,
    input  logic [DATA_WIDTH-1:0]       i_dcache_write_data,
    input  logic [7:0]                  i_dcache_write_strobe,
    output logic                        o_dcache_write_done,

    output logic                        o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,

    output logic                        o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
    output logic [DATA_WIDTH-1:0]       o_mem_write_data,
    output logic [7:0]                  o_write_strobe,
    input  logic                        i_mem_write_done,

    output logic                        o_timeout_err
);

    arb_state_t state;
    side_t      rr_ptr;
    logic       gnt_side;
    logic       gnt_vld;
    logic       tmo_abort;

    mem_arb_rr_pick u_pick (
        .i_req_i    (i_icache_read_req),
        .i_req_d    (i_dcache_write_valid | i_dcache_read_req),
        .i_ptr      (rr_ptr),
        .o_gnt_side (gnt_side),
        .o_gnt_vld  (gnt_vld)
    );

`ifdef MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        busy;

    assign busy = (state == IRD) || (state == DRD) || (state == DWR);

    // A real done on the same edge as the limit wins over the abort.
    always_comb begin
        tmo_abort = busy && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) &&
                    !((state == DWR) ? i_mem_write_done : i_mem_read_done);
    end

    // Counter is zero on the first busy cycle after every grant because it
    // is held clear in IDLE and RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt       <= '0;
            o_timeout_err <= 1'b0;
        end else begin
            tmo_cnt <= busy ? tmo_cnt + 16'd1 : '0;
            if (tmo_abort) begin
                o_timeout_err <= 1'b1;
            end
        end
    end
`else
    logic [15:0] unused_tmo_limit;

    assign unused_tmo_limit = 16'(TIMEOUT_CYCLES);
    assign tmo_abort        = 1'b0;
    assign o_timeout_err    = 1'b0;
`endif

    // Grant FSM and datapath registers. The memory-side address/data/strobe
    // outputs are the latched copies of the granted request, so the caches
    // may change their inputs mid-transaction without affecting memory.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= IDLE;
            rr_ptr              <= SIDE_D;
            o_icache_cache_line <= '0;
            o_icache_read_done  <= 1'b0;
            o_dcache_cache_line <= '0;
            o_dcache_read_done  <= 1'b0;
            o_dcache_write_done <= 1'b0;
            o_mem_read_req      <= 1'b0;
            o_mem_read_address  <= '0;
            o_mem_write_valid   <= 1'b0;
            o_mem_write_address <= '0;
            o_mem_write_data    <= '0;
            o_write_strobe      <= '0;
        end else begin
            o_icache_read_done  <= 1'b0;
            o_dcache_read_done  <= 1'b0;
            o_dcache_write_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        if (gnt_side == SIDE_I) begin
                            rr_ptr             <= SIDE_I;
                            o_mem_read_req     <= 1'b1;
                            o_mem_read_address <= i_icache_read_address;
                            state              <= IRD;
                        end else begin
                            rr_ptr <= SIDE_D;
                            if (i_dcache_write_valid) begin
                                o_mem_write_valid   <= 1'b1;
                                o_mem_write_address <= i_dcache_write_address + DATA_OFFSET;
                                o_mem_write_data    <= i_dcache_write_data;
                                o_write_strobe      <= i_dcache_write_strobe;
                                state               <= DWR;
                            end else begin
                                o_mem_read_req     <= 1'b1;
                                o_mem_read_address <= i_dcache_read_address + DATA_OFFSET;
                                state              <= DRD;
                            end
                        end
                    end
                end

                IRD, DRD: begin
                    if (i_mem_read_done || tmo_abort) begin
                        o_mem_read_req     <= 1'b0;
                        o_mem_read_address <= '0;
                        if (state == IRD) begin
                            o_icache_cache_line <= i_mem_read_done ? i_cache_line : '0;
                            o_icache_read_done  <= 1'b1;
                        end else begin
                            o_dcache_cache_line <= i_mem_read_done ? i_cache_line : '0;
                            o_dcache_read_done  <= 1'b1;
                        end
                        state <= RESP;
                    end
                end

                DWR: begin
                    if (i_mem_write_done || tmo_abort) begin
                        o_mem_write_valid   <= 1'b0;
                        o_mem_write_address <= '0;
                        o_mem_write_data    <= '0;
                        o_write_strobe      <= '0;
                        o_dcache_write_done <= 1'b1;
                        state               <= RESP;
                    end
                end

                // Requester sees its done pulse here and drops its level.
                RESP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_icache_read_req;
    logic [31:0]  i_icache_read_address;
    logic [255:0] o_icache_cache_line;
    logic         o_icache_read_done;
    logic         i_dcache_read_req;
    logic [31:0]  i_dcache_read_address;
    logic [255:0] o_dcache_cache_line;
    logic         o_dcache_read_done;
    logic         i_dcache_write_valid;
    logic [31:0]  i_dcache_write_address;
    logic [31:0]  i_dcache_write_data;
    logic [7:0]   i_dcache_write_strobe;
    logic         o_dcache_write_done;
    logic         o_mem_read_req;
    logic [31:0]  o_mem_read_address;
    logic         i_mem_read_done;
    logic [255:0] i_cache_line;
    logic         o_mem_write_valid;
    logic [31:0]  o_mem_write_address;
    logic [31:0]  o_mem_write_data;
    logic [7:0]   o_write_strobe;
    logic         i_mem_write_done;
    logic         o_timeout_err;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(
        .DATA_WIDTH       (32),
        .ADDR_WIDTH       (32),
        .CACHE_LINE_WIDTH (256),
        .DATA_OFFSET      (32'h0000_D000),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_icache_read_req      (i_icache_read_req),
        .i_icache_read_address  (i_icache_read_address),
        .o_icache_cache_line    (o_icache_cache_line),
        .o_icache_read_done     (o_icache_read_done),
        .i_dcache_read_req      (i_dcache_read_req),
        .i_dcache_read_address  (i_dcache_read_address),
        .o_dcache_cache_line    (o_dcache_cache_line),
        .o_dcache_read_done     (o_dcache_read_done),
        .i_dcache_write_valid   (i_dcache_write_valid),
        .i_dcache_write_address (i_dcache_write_address),
        .i_dcache_write_data    (i_dcache_write_data),
        .i_dcache_write_strobe  (i_dcache_write_strobe),
        .o_dcache_write_done    (o_dcache_write_done),
        .o_mem_read_req         (o_mem_read_req),
        .o_mem_read_address     (o_mem_read_address),
        .i_mem_read_done        (i_mem_read_done),
        .i_cache_line           (i_cache_line),
        .o_mem_write_valid      (o_mem_write_valid),
        .o_mem_write_address    (o_mem_write_address),
        .o_mem_write_data       (o_mem_write_data),
        .o_write_strobe         (o_write_strobe),
        .i_mem_write_done       (i_mem_write_done),
        .o_timeout_err          (o_timeout_err)
    );

    // Expected memory-side grants, in order.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        bit          lat;   // check request-to-memory latency of 1 cycle
        bit          gap;   // check one-cycle RESP gap after previous done
    } gnt_t;

    // Expected cache-side completions, in order. port: 0 I-rd, 1 D-rd, 2 D-wr.
    typedef struct {
        int           port;
        logic [255:0] iline;
        logic [255:0] dline;
        bit           tmo;
    } done_t;

    gnt_t  gq[$];
    done_t dq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_req = 0;
    int mem_done_cyc = 0;
    int rise_cyc = 0;
    int last_done_cyc = 0;
    int mem_delay = 3;
    bit mem_hold = 1'b0;
    logic [255:0] cur_iline = '0;
    logic [255:0] cur_dline = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_rd(input logic [31:0] a, input bit lat, input bit gap);
        gq.push_back('{wr: 1'b0, addr: a, data: 32'h0, strb: 8'h0, lat: lat, gap: gap});
    endfunction

    function automatic void push_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                                    input bit lat, input bit gap);
        gq.push_back('{wr: 1'b1, addr: a, data: d, strb: s, lat: lat, gap: gap});
    endfunction

    function automatic void push_done(input int port, input logic [255:0] line, input bit tmo);
        if (port == 0) cur_iline = line;
        if (port == 1) cur_dline = line;
        dq.push_back('{port: port, iline: cur_iline, dline: cur_dline, tmo: tmo});
    endfunction

    // Memory model: completes after mem_delay+1 cycles, returns {8{address}},
    // and throws a stray opposite-channel done pulse at the 2nd busy cycle.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge i_clk);
            i_mem_read_done  = 1'b0;
            i_mem_write_done = 1'b0;
            i_cache_line     = {8{32'hBAD0_BAD0}};
            if (mem_hold || !(o_mem_read_req || o_mem_write_valid)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 2) begin
                    if (o_mem_read_req) i_mem_write_done = 1'b1;
                    else                i_mem_read_done  = 1'b1;
                end
                if (cnt == mem_delay + 1) begin
                    if (o_mem_read_req) begin
                        i_mem_read_done = 1'b1;
                        i_cache_line    = {8{o_mem_read_address}};
                    end else begin
                        i_mem_write_done = 1'b1;
                    end
                    mem_done_cyc = cyc;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT starts a memory request
    // or pulses a cache done.
    initial begin
        logic  prev_rd = 1'b0;
        logic  prev_wr = 1'b0;
        gnt_t  g;
        done_t d;
        int    nd;
        int    port;
        forever begin
            @(negedge i_clk);
            if ((o_mem_read_req && !prev_rd) || (o_mem_write_valid && !prev_wr)) begin
                chk("grant_expected", gq.size() != 0, 1'b1);
                if (gq.size() != 0) begin
                    g = gq.pop_front();
                    chk("mem_is_write", o_mem_write_valid, g.wr);
                    chk("mem_addr", o_mem_write_valid ? o_mem_write_address : o_mem_read_address, g.addr);
                    if (g.wr) begin
                        chk("mem_wdata", o_mem_write_data, g.data);
                        chk("mem_wstrb", o_write_strobe, g.strb);
                    end
                    if (g.lat) chk("req_latency", cyc - t_req, 1);
                    if (g.gap) chk("resp_gap", cyc - last_done_cyc, 2);
                    rise_cyc = cyc;
                end
            end
            prev_rd = o_mem_read_req;
            prev_wr = o_mem_write_valid;

            nd = int'(o_icache_read_done) + int'(o_dcache_read_done) + int'(o_dcache_write_done);
            if (nd != 0) begin
                chk("done_onehot", nd, 1);
                port = o_icache_read_done ? 0 : (o_dcache_read_done ? 1 : 2);
                chk("done_expected", dq.size() != 0, 1'b1);
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    chk("done_port", port, d.port);
                    chk("icache_line", o_icache_cache_line, d.iline);
                    chk("dcache_line", o_dcache_cache_line, d.dline);
                    if (d.tmo) chk("timeout_latency", cyc - rise_cyc, 16);
                    else       chk("done_latency", cyc - mem_done_cyc, 1);
                end
                last_done_cyc = cyc;
            end
        end
    end

    task automatic wait_done(input int port);
        bit got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge i_clk);
            case (port)
                0:       got = o_icache_read_done;
                1:       got = o_dcache_read_done;
                default: got = o_dcache_write_done;
            endcase
        end
        chk("done_seen", got, 1'b1);
    endtask

    task automatic iread(input logic [31:0] a);
        @(negedge i_clk);
        i_icache_read_address = a;
        i_icache_read_req     = 1'b1;
        t_req                 = cyc;
        wait_done(0);
        i_icache_read_req     = 1'b0;
    endtask

    task automatic dread(input logic [31:0] a);
        @(negedge i_clk);
        i_dcache_read_address = a;
        i_dcache_read_req     = 1'b1;
        t_req                 = cyc;
        wait_done(1);
        i_dcache_read_req     = 1'b0;
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        @(negedge i_clk);
        i_dcache_write_address = a;
        i_dcache_write_data    = d;
        i_dcache_write_strobe  = s;
        i_dcache_write_valid   = 1'b1;
        t_req                  = cyc;
        wait_done(2);
        i_dcache_write_valid   = 1'b0;
        i_dcache_write_data    = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1;
        i_icache_read_req = 1'b0;  i_icache_read_address = '0;
        i_dcache_read_req = 1'b0;  i_dcache_read_address = '0;
        i_dcache_write_valid = 1'b0; i_dcache_write_address = '0;
        i_dcache_write_data = '0;  i_dcache_write_strobe = '0;
        i_mem_read_done = 1'b0;    i_mem_write_done = 1'b0;
        i_cache_line = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;

        // Reset state
        chk("rst_mem_read_req", o_mem_read_req, 1'b0);
        chk("rst_mem_write_valid", o_mem_write_valid, 1'b0);
        chk("rst_mem_read_addr", o_mem_read_address, 32'h0);
        chk("rst_icache_line", o_icache_cache_line, 256'h0);
        chk("rst_dcache_line", o_dcache_cache_line, 256'h0);
        chk("rst_dones", {o_icache_read_done, o_dcache_read_done, o_dcache_write_done}, 3'b000);
        chk("rst_timeout_err", o_timeout_err, 1'b0);

        // I and D held together: strict alternation starting with I.
        mem_delay = 3;
        push_rd(32'h0000_0200, 1'b1, 1'b0); push_done(0, {8{32'h0000_0200}}, 1'b0);
        push_rd(32'h0000_D010, 1'b0, 1'b1); push_done(1, {8{32'h0000_D010}}, 1'b0);
        push_rd(32'h0000_0204, 1'b0, 1'b1); push_done(0, {8{32'h0000_0204}}, 1'b0);
        push_rd(32'h0000_D014, 1'b0, 1'b1); push_done(1, {8{32'h0000_D014}}, 1'b0);
        push_rd(32'h0000_0208, 1'b0, 1'b1); push_done(0, {8{32'h0000_0208}}, 1'b0);
        push_rd(32'h0000_D018, 1'b0, 1'b1); push_done(1, {8{32'h0000_D018}}, 1'b0);
        fork
            begin iread(32'h200); iread(32'h204); iread(32'h208); end
            begin dread(32'h10);  dread(32'h14);  dread(32'h18);  end
        join
        repeat (3) @(negedge i_clk);

        // I-read alone, memory done 5 cycles after the request.
        mem_delay = 5;
        push_rd(32'h0000_0100, 1'b1, 1'b0); push_done(0, {8{32'h0000_0100}}, 1'b0);
        iread(32'h100);
        repeat (2) @(negedge i_clk);

        // D-read gets the data offset; I line must not move.
        mem_delay = 3;
        push_rd(32'h0000_D040, 1'b1, 1'b0); push_done(1, {8{32'h0000_D040}}, 1'b0);
        dread(32'h40);
        repeat (2) @(negedge i_clk);

        // D-write and D-read pending together: write goes first.
        push_wr(32'h0000_D008, 32'hDEAD_BEEF, 8'h0F, 1'b1, 1'b0); push_done(2, '0, 1'b0);
        push_rd(32'h0000_D00C, 1'b0, 1'b1); push_done(1, {8{32'h0000_D00C}}, 1'b0);
        fork
            dwrite(32'h8, 32'hDEAD_BEEF, 8'h0F);
            dread(32'hC);
        join
        repeat (2) @(negedge i_clk);

        // Offset addition wraps modulo 2^32.
        push_rd(32'h0000_0010, 1'b1, 1'b0); push_done(1, {8{32'h0000_0010}}, 1'b0);
        dread(32'hFFFF_3010);
        repeat (2) @(negedge i_clk);

        // Reset during DRD: request drops, no done pulse.
        mem_hold = 1'b1;
        push_rd(32'h0000_D020, 1'b1, 1'b0);
        @(negedge i_clk);
        i_dcache_read_address = 32'h20;
        i_dcache_read_req     = 1'b1;
        t_req                 = cyc;
        repeat (4) @(negedge i_clk);
        chk("drd_held", o_mem_read_req, 1'b1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_mid_read_req", o_mem_read_req, 1'b0);
        chk("rst_mid_no_done", o_dcache_read_done, 1'b0);
        chk("rst_mid_dline", o_dcache_cache_line, 256'h0);
        i_rst = 1'b0;
        i_dcache_read_req = 1'b0;
        mem_hold = 1'b0;
        cur_iline = '0;
        cur_dline = '0;
        repeat (3) @(negedge i_clk);
        push_rd(32'h0000_D024, 1'b1, 1'b0); push_done(1, {8{32'h0000_D024}}, 1'b0);
        dread(32'h24);
        repeat (2) @(negedge i_clk);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no memory done at all.
        mem_hold = 1'b1;
        push_rd(32'h0000_0300, 1'b1, 1'b0); push_done(0, 256'h0, 1'b1);
        iread(32'h300);
        chk("timeout_err_set", o_timeout_err, 1'b1);
        repeat (5) @(negedge i_clk);
        chk("timeout_err_sticky", o_timeout_err, 1'b1);
        mem_hold = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("timeout_err_cleared", o_timeout_err, 1'b0);
`else
        chk("timeout_err_off", o_timeout_err, 1'b0);
`endif

        repeat (5) @(negedge i_clk);
        chk("grant_queue_drained", gq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
